// File: rtl/freq_gate_counter_if.sv
// Result and control bundle between the frequency gate counter and its neighbours.
// The master side is the counter; the slave side is the settle generator plus the display/UART consumer.
interface freq_gate_counter_if #(
  parameter int CNT_W = 32
);
  logic             settled;
  logic             sigIn;
  logic             resultAck;
  logic [CNT_W-1:0] resultCount;
  logic             resultValid;
  logic             overflow;
  logic             busy;

  modport master (
    input  settled, sigIn, resultAck,
    output resultCount, resultValid, overflow, busy
  );

  modport slave (
    output settled, sigIn, resultAck,
    input  resultCount, resultValid, overflow, busy
  );
endinterface

// File: rtl/freq_gate_counter.sv
// Opens one GATE_CYCLES window after settled rises, counts sigIn rising edges, and holds the result until acked.
// Define FREQ_GATE_CONTINUOUS_EN to re-arm on ack while settled stays high instead of needing a settled toggle.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 26
) (
  input  logic                 sysClk,
  input  logic                 sysRst,
  freq_gate_counter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, GATE, DONE, REARM} state_t;

  localparam logic [GATE_W-1:0] TIMER_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [GATE_W-1:0] timer_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  result_q;
  logic              ovf_q;
  logic              valid_q;
  logic              busy_q;
  logic              edge_w;
  logic              last_w;

  assign edge_w = s2_q & ~s3_q;
  assign last_w = (timer_q == TIMER_LAST);

  // Saturating edge count; an edge arriving at all-ones only raises the flag.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (edge_w) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      timer_q  <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      s1_q <= bus.sigIn;
      s2_q <= s1_q;
      s3_q <= s2_q;

      if (bus.resultAck && valid_q) valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (bus.settled && !valid_q) begin
            timer_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= GATE;
          end
        end
        GATE: begin
          if (!bus.settled) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            if (last_w) begin
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              timer_q <= timer_q + GATE_W'(1);
            end
          end
        end
        DONE: begin
          // Placed after the ack clear so a coincident ack cannot drop the new result.
          result_q <= cnt_q;
          ovf_q    <= sat_q;
          valid_q  <= 1'b1;
`ifdef FREQ_GATE_CONTINUOUS_EN
          state_q  <= IDLE;
`else
          state_q  <= REARM;
`endif
        end
        REARM: begin
          if (!bus.settled) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resultCount = result_q;
  assign bus.resultValid = valid_q;
  assign bus.overflow    = ovf_q;
  assign bus.busy        = busy_q;

endmodule
